// File: rtl/mux_pipe_pkg.sv
// Shared constants and entry type for the lane-select pipe.
// Default lane count/width and the buffered entry layout.
package mux_pkg;

    localparam int MUX_N     = 3;
    localparam int MUX_WIDTH = 32;
    localparam int MUX_SEL_W = $clog2(MUX_N);

    typedef struct packed {
        logic [MUX_WIDTH-1:0] data;
        logic [MUX_SEL_W-1:0] sel;
        logic                 err;
    } entry_t;

endpackage

// File: rtl/mux_pipe_if.sv
// Producer/consumer handshake bundle for mux_pipe.
// slave is the block side, master the driver side.
interface mux_pipe_if
    import mux_pkg::*;
#(
    parameter int N     = MUX_N,
    parameter int WIDTH = MUX_WIDTH
) ();

    localparam int SEL_W = $clog2(N);

    logic [N*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]   in_sel;
    logic               in_valid;
    logic               in_ready;
    logic               flush;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_sel;
    logic               out_err;
    logic               out_valid;
    logic               out_ready;

    modport slave (
        input  in_data, in_sel, in_valid,
        input  flush, out_ready,
        output in_ready, out_data, out_sel,
        output out_err, out_valid
    );

    modport master (
        output in_data, in_sel, in_valid,
        output flush, out_ready,
        input  in_ready, out_data, out_sel,
        input  out_err, out_valid
    );

endinterface

// File: rtl/mux_pipe_skid_fifo2.sv
// Two-entry FIFO; slot 0 is always the head.
// Flush wins over push/pop and empties the buffer.
module skid_fifo2
    import mux_pkg::*;
#(
    parameter type T = entry_t
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic       i_flush,
    input  T           i_din,
    output T           o_head,
    output logic [1:0] o_count
);

    T           r_slot0;
    T           r_slot1;
    logic [1:0] r_count;
    logic       w_wr;
    logic       w_rd;

    assign w_wr    = i_push && !i_flush;
    assign w_rd    = i_pop && !i_flush;
    assign o_head  = r_slot0;
    assign o_count = r_count;

    // Slot/count update; a pop shifts slot 1 forward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_slot0 <= '0;
            r_slot1 <= '0;
        end else begin
            unique case (1'b1)
                i_flush: begin
                    r_count <= 2'd0;
                end
                w_wr && !w_rd: begin
                    if (r_count == 2'd0)
                        r_slot0 <= i_din;
                    else
                        r_slot1 <= i_din;
                    r_count <= r_count + 2'd1;
                end
                w_rd && !w_wr: begin
                    r_slot0 <= r_slot1;
                    r_count <= r_count - 2'd1;
                end
                w_wr && w_rd: begin
                    r_slot0 <= i_din;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mux_pipe.sv
// Lane-select front end feeding a 2-entry buffer.
// Out-of-range selects capture zero data with err set.
module mux_pipe
    import mux_pkg::*;
#(
    parameter int N     = MUX_N,
    parameter int WIDTH = MUX_WIDTH
) (
    input  logic      clk,
    input  logic      rst_n,
    mux_pipe_if.slave bus
);

    localparam int SEL_W = $clog2(N);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] sel;
        logic             err;
    } ent_t;

    logic             r_live;
    logic [1:0]       w_count;
    logic [WIDTH-1:0] w_lane;
    logic             w_hit;
    logic             w_push;
    logic             w_pop;
    logic             w_busy;
    ent_t             w_din;
    ent_t             w_head;

    // Hold off acceptance until the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_live <= 1'b0;
        else
            r_live <= 1'b1;
    end

    // Pick the addressed lane; no match leaves zero data.
    always_comb begin
        w_lane = '0;
        w_hit  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (bus.in_sel == SEL_W'(k)) begin
                w_lane = bus.in_data[k*WIDTH +: WIDTH];
                w_hit  = 1'b1;
            end
        end
    end

    assign w_din = '{data: w_lane,
                     sel:  bus.in_sel,
                     err:  !w_hit};

    assign bus.in_ready = r_live
                        && (w_count != 2'd2)
                        && !bus.flush;

    assign w_push = bus.in_valid && bus.in_ready;
    assign w_busy = (w_count != 2'd0);
    assign w_pop  = w_busy && bus.out_ready;

    assign bus.out_valid = w_busy;
    assign bus.out_data  = w_busy ? w_head.data : '0;
    assign bus.out_sel   = w_busy ? w_head.sel : '0;
    assign bus.out_err   = w_busy && w_head.err;

    skid_fifo2 #(
        .T (ent_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.flush),
        .i_din   (w_din),
        .o_head  (w_head),
        .o_count (w_count)
    );

endmodule

// File: tb/tb_mux_pipe.sv
// Directed bench for mux_pipe: vector table plus
// handshake, flush and reset sequences.
module tb_mux_pipe;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    mux_pipe_if #(.N(3), .WIDTH(32)) bus ();

    mux_pipe #(.N(3), .WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] l0;
        logic [31:0] l1;
        logic [31:0] l2;
        logic [31:0] ed;
        logic        ee;
    } vec_t;

    vec_t v[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h",
                     nm, act, exp);
        end
    endtask

    task automatic push_lane0(input logic [31:0] d);
        bus.in_sel   = 2'd0;
        bus.in_data  = {32'h0, 32'h0, d};
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t x,
                           input string nm);
        bus.in_data   = {x.l2, x.l1, x.l0};
        bus.in_sel    = x.sel;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        chk({nm, ".rdy"}, 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk({nm, ".vld"}, 32'(bus.out_valid), 32'd1);
        chk({nm, ".data"}, bus.out_data, x.ed);
        chk({nm, ".sel"}, 32'(bus.out_sel), 32'(x.sel));
        chk({nm, ".err"}, 32'(bus.out_err), 32'(x.ee));
        tick();
        chk({nm, ".vld0"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        errors = 0;
        checks = 0;

        v[0] = '{2'd1, 32'h11, 32'h22, 32'h33, 32'h22, 1'b0};
        v[1] = '{2'd0, 32'hA5A5_0001, 32'h2, 32'h3,
                 32'hA5A5_0001, 1'b0};
        v[2] = '{2'd2, 32'h1, 32'h2, 32'hFFFF_FFFF,
                 32'hFFFF_FFFF, 1'b0};
        v[3] = '{2'd3, 32'h11, 32'h22, 32'h33, 32'h0, 1'b1};
        v[4] = '{2'd1, 32'hDEAD_BEEF, 32'h8000_0000, 32'h7,
                 32'h8000_0000, 1'b0};

        rst_n         = 1'b0;
        bus.in_data   = '0;
        bus.in_sel    = '0;
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        #3;
        chk("rst.vld", 32'(bus.out_valid), 32'd0);
        chk("rst.rdy", 32'(bus.in_ready), 32'd0);
        chk("rst.data", bus.out_data, 32'd0);
        chk("rst.sel", 32'(bus.out_sel), 32'd0);
        chk("rst.err", 32'(bus.out_err), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        chk("rel.rdy0", 32'(bus.in_ready), 32'd0);
        tick();
        chk("rel.rdy1", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 5; i++)
            run_vec(v[i], $sformatf("vec%0d", i));

        // backpressure, ordering, accept+pop at one entry
        bus.out_ready = 1'b0;
        push_lane0(32'hA);
        push_lane0(32'hB);
        chk("bp.rdy0", 32'(bus.in_ready), 32'd0);
        chk("bp.head", bus.out_data, 32'hA);
        bus.in_data  = {32'h0, 32'h0, 32'hC};
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("bp.hold", bus.out_data, 32'hA);
        chk("bp.holdv", 32'(bus.out_valid), 32'd1);
        chk("bp.rdyh", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        chk("bp.firstA", bus.out_data, 32'hA);
        tick();
        chk("bp.secB", bus.out_data, 32'hB);
        chk("bp.rdy1", 32'(bus.in_ready), 32'd1);
        bus.in_data  = {32'h0, 32'h0, 32'hD};
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("ap.vld", 32'(bus.out_valid), 32'd1);
        chk("ap.headD", bus.out_data, 32'hD);
        tick();
        chk("ap.empty", 32'(bus.out_valid), 32'd0);

        // back-to-back stream, no bubbles
        bus.out_ready = 1'b1;
        bus.in_sel    = 2'd1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_data = {32'h0, 32'h100 + 32'(i), 32'h0};
            tick();
            chk($sformatf("st%0d.vld", i),
                32'(bus.out_valid), 32'd1);
            chk($sformatf("st%0d.data", i),
                bus.out_data, 32'h100 + 32'(i));
            chk($sformatf("st%0d.rdy", i),
                32'(bus.in_ready), 32'd1);
        end
        bus.in_valid = 1'b0;
        tick();
        chk("st.end", 32'(bus.out_valid), 32'd0);

        // flush with a full buffer
        bus.out_ready = 1'b0;
        push_lane0(32'h51);
        push_lane0(32'h52);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        chk("fl.rdy0", 32'(bus.in_ready), 32'd0);
        chk("fl.vld", 32'(bus.out_valid), 32'd1);
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("fl.empty", 32'(bus.out_valid), 32'd0);
        chk("fl.rdy1", 32'(bus.in_ready), 32'd1);
        tick();

        // async reset with two entries held
        push_lane0(32'h61);
        push_lane0(32'h62);
        chk("ar.full", 32'(bus.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar.vld", 32'(bus.out_valid), 32'd0);
        chk("ar.rdy", 32'(bus.in_ready), 32'd0);
        chk("ar.data", bus.out_data, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar.rdy1", 32'(bus.in_ready), 32'd1);
        run_vec(v[0], "ar.vec");

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_pipe.md
MUX_PIPE -- requirements
Module: mux_pipe

Interface
REQ-001 Parameter N, default 3: number of input lanes, N >= 2.
REQ-002 Parameter WIDTH, default 32: data width per lane in bits.
REQ-003 Parameter SEL_W, default $clog2(N): select width; it SHALL be derived, never overridden.
REQ-004 clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1: reset, asynchronous, active-low.
REQ-006 in_data  input  N*WIDTH: flattened lanes; lane k SHALL occupy bits [k*WIDTH +: WIDTH].
REQ-007 in_sel  input  SEL_W: lane index to capture.
REQ-008 in_valid  input  1: producer offers in_data/in_sel this cycle.
REQ-009 in_ready  output  1: block accepts this cycle.
REQ-010 flush  input  1: synchronous discard of all buffered entries.
REQ-011 out_data  output  WIDTH: selected lane data at buffer head.
REQ-012 out_sel  output  SEL_W: lane index captured with the head entry.
REQ-013 out_err  output  1: head entry was captured with in_sel >= N.
REQ-014 out_valid  output  1: head entry present.
REQ-015 out_ready  input  1: consumer takes head this cycle.

Function
REQ-016 Accept SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-017 The buffer SHALL hold 2 entries in FIFO order, each entry being {data, sel, err}; count ranges 0..2.
REQ-018 in_ready SHALL equal (count < 2) && !flush, combinationally from registered count and flush only; it SHALL NOT depend on out_ready.
REQ-019 Captured data SHALL be lane in_sel of in_data; if in_sel >= N, the captured data SHALL be 0 and err SHALL be 1.
REQ-020 Latency: an entry accepted in cycle t SHALL appear with out_valid=1 in cycle t+1 when the buffer was empty.
REQ-021 out_valid SHALL equal (count != 0); out_data/out_sel/out_err SHALL reflect the head entry and be 0 when count == 0.
REQ-022 Holding rule: while out_valid && !out_ready, out_data/out_sel/out_err SHALL remain stable.
REQ-023 Simultaneous accept and pop at count == 1: count SHALL stay 1, and the new entry SHALL become head in the next cycle.
REQ-024 Simultaneous accept and pop at count == 2: no accept is possible (in_ready=0); count SHALL become 1.
REQ-025 Accept with no pop SHALL increment count; pop with no accept SHALL decrement count.
REQ-026 flush SHALL set count to 0 in the next cycle regardless of in_valid/out_ready; a pop in the flush cycle SHALL still count as a handshake for the consumer.
REQ-027 No entry SHALL be duplicated, dropped (except by flush), or reordered.

Reset
REQ-028 While rst_n=0: count=0, out_valid=0, out_data=0, out_sel=0, out_err=0, in_ready=0.
REQ-029 in_ready SHALL rise in the first clock edge after rst_n deasserts.
REQ-030 Reset asserted mid-transfer SHALL discard all entries immediately, without waiting for a clock edge.

Structure
REQ-031 Package mux_pkg SHALL hold the default N/WIDTH constants and the entry struct type {data, sel, err}.
REQ-032 Sub-module skid_fifo2 SHALL implement the 2-entry buffer (push/pop/flush/count); mux_pipe SHALL contain the lane-select logic and the handshake glue only.

Verification
REQ-033 Reset, then in_sel=1, lanes {0x11,0x22,0x33}, in_valid pulse, out_ready=1 -> out_data=0x22, out_sel=1, out_valid for exactly one cycle, 1 cycle after the accept.
REQ-034 out_ready=0, push 0xA then 0xB -> in_ready=0 after the second push and the third offer is held off; raise out_ready -> 0xA then 0xB in order.
REQ-035 in_sel=3 with N=3 -> out_data=0, out_err=1, out_sel=3.
REQ-036 Continuous in_valid and out_ready=1 for 10 beats -> one output per cycle, no bubbles, order preserved.
REQ-037 Buffer full, assert flush for one cycle -> out_valid=0 next cycle, in_ready=0 during flush, then 1.
REQ-038 rst_n=0 asynchronously with 2 entries held -> out_valid=0 before the next clock edge; after release, the first beat behaves as in REQ-033.
